// File: rtl/fnn_cfg_pkg.sv
// fnn_cfg_pkg: shared state encoding and default widths for the neuron configuration loader
package fnn_cfg_pkg;
    localparam int CFG_W = 32;
    localparam int MAX_WEIGHTS_DEF = 784;
    localparam int MAX_NEURONS_DEF = 64;
    localparam int WCNT_W = $clog2(MAX_WEIGHTS_DEF + 1);
    localparam int NCNT_W = $clog2(MAX_NEURONS_DEF + 1);
    typedef enum logic [1:0] {IDLE, WEIGHT, BIAS, FIN} state_t;
endpackage

// File: rtl/fnn_weight_loader.sv
// fnn_weight_loader: turns a flat weight/bias word stream into per-neuron configuration strobes for one layer
module fnn_weight_loader
    import fnn_cfg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int MAX_WEIGHTS = MAX_WEIGHTS_DEF,
    parameter int MAX_NEURONS = MAX_NEURONS_DEF,
    parameter int unsigned NEURON_BASE = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic [CFG_W-1:0] cfg_layer,
    input  logic [$clog2(MAX_NEURONS+1)-1:0] cfg_num_neurons,
    input  logic [$clog2(MAX_WEIGHTS+1)-1:0] cfg_num_weights,
    input  logic [DATA_W-1:0] s_data,
    input  logic s_valid,
    output logic s_ready,
    output logic weightValid,
    output logic [CFG_W-1:0] weightValue,
    output logic biasValid,
    output logic [CFG_W-1:0] biasValue,
    output logic [CFG_W-1:0] config_layer_num,
    output logic [CFG_W-1:0] config_neuron_num,
    output logic busy,
    output logic done
);
    localparam int WW = $clog2(MAX_WEIGHTS + 1);
    localparam int NW = $clog2(MAX_NEURONS + 1);

    state_t state;
    logic [WW-1:0] num_w, wcnt;
    logic [NW-1:0] num_n, ncnt;
    logic beat, last_w, last_n;

    assign beat = s_valid & s_ready;
    assign last_w = wcnt == num_w - 1'b1;
    assign last_n = ncnt == num_n - 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            s_ready <= 1'b0;
            weightValid <= 1'b0;
            weightValue <= '0;
            biasValid <= 1'b0;
            biasValue <= '0;
            config_layer_num <= '0;
            config_neuron_num <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            num_w <= '0;
            num_n <= '0;
            wcnt <= '0;
            ncnt <= '0;
        end else begin
            weightValid <= 1'b0;
            biasValid <= 1'b0;
            done <= 1'b0;
            // trails the neuron counter by a cycle so it moves only after the bias strobe
            if (state != IDLE) config_neuron_num <= CFG_W'(NEURON_BASE) + CFG_W'(ncnt);
            case (state)
                IDLE: if (start) begin
                    num_n <= cfg_num_neurons;
                    num_w <= cfg_num_weights;
                    wcnt <= '0;
                    ncnt <= '0;
                    config_layer_num <= cfg_layer;
                    config_neuron_num <= CFG_W'(NEURON_BASE);
                    busy <= 1'b1;
                    s_ready <= cfg_num_neurons != '0;
                    state <= cfg_num_neurons == '0 ? FIN : cfg_num_weights == '0 ? BIAS : WEIGHT;
                end
                WEIGHT: if (beat) begin
                    weightValid <= 1'b1;
                    weightValue <= CFG_W'(s_data);
                    wcnt <= last_w ? '0 : wcnt + 1'b1;
                    if (last_w) state <= BIAS;
                end
                BIAS: if (beat) begin
                    biasValid <= 1'b1;
                    biasValue <= CFG_W'(s_data);
                    if (last_n) begin
                        s_ready <= 1'b0;
                        state <= FIN;
                    end else begin
                        ncnt <= ncnt + 1'b1;
                        state <= num_w == '0 ? BIAS : WEIGHT;
                    end
                end
                FIN: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fnn_weight_loader.sv
// tb_fnn_weight_loader: directed and randomized loads checked against a stream-order model of the configuration bus
module tb_fnn_weight_loader;
    localparam int NB = 0;
    typedef struct packed {
        logic bias;
        logic [31:0] val;
        logic [31:0] neuron;
        logic [31:0] layer;
    } ev_t;

    logic clk = 0, rst = 1, start = 0, s_valid = 0;
    logic [31:0] cfg_layer = 0, s_data = 0;
    logic [6:0] cfg_num_neurons = 0;
    logic [9:0] cfg_num_weights = 0;
    logic s_ready, weightValid, biasValid, busy, done;
    logic [31:0] weightValue, biasValue, config_layer_num, config_neuron_num;

    logic [31:0] stim[$];
    ev_t obs[$], exp_q[$];
    int n_chk = 0, n_fail = 0;
    int done_cnt, done_cyc, last_bias, dual;
    bit ready_seen, busy1;

    fnn_weight_loader #(.NEURON_BASE(NB)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_layer(cfg_layer),
        .cfg_num_neurons(cfg_num_neurons), .cfg_num_weights(cfg_num_weights),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .weightValid(weightValid), .weightValue(weightValue),
        .biasValid(biasValid), .biasValue(biasValue),
        .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Expected bus traffic: per neuron, nw weights then one bias, neurons in ascending order
    function automatic void build(input logic [31:0] layer, input int nn, input int nw);
        exp_q.delete();
        for (int n = 0; n < nn; n++)
            for (int j = 0; j <= nw; j++)
                exp_q.push_back('{j == nw, stim[n * (nw + 1) + j], 32'(NB + n), layer});
    endfunction

    // gaps: 0 = always valid, 1 = valid toggles, 2 = random; cycle 0 carries the start pulse
    task automatic do_load(input logic [31:0] layer, input int nn, input int nw, input int gaps, input bit busy_start);
        int idx = 0;
        obs.delete();
        done_cnt = 0; done_cyc = -1; last_bias = -1; dual = 0; ready_seen = 0; busy1 = 0;
        @(posedge clk); #1;
        for (int c = 0; c < 4000; c++) begin
            start = (c == 0) || (busy_start && c == 3);
            cfg_layer = c == 0 ? layer : ~layer;
            cfg_num_neurons = c == 0 ? 7'(nn) : 7'(nn + 1);
            cfg_num_weights = c == 0 ? 10'(nw) : 10'(nw + 2);
            s_valid = idx < stim.size() && (gaps == 0 || (gaps == 1 ? c % 2 == 0 : $urandom_range(0, 2) != 0));
            s_data = s_valid ? stim[idx] : $urandom;
            @(negedge clk);
            if (weightValid || biasValid)
                obs.push_back('{biasValid, biasValid ? biasValue : weightValue, config_neuron_num, config_layer_num});
            if (weightValid && biasValid) dual++;
            if (biasValid) last_bias = c;
            if (s_ready) ready_seen = 1;
            if (c == 1) busy1 = busy;
            if (s_valid && s_ready) idx++;
            if (done) begin
                done_cnt++;
                done_cyc = c;
                break;
            end
            @(posedge clk); #1;
        end
        start = 0;
        s_valid = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({s_ready, weightValid, biasValid, busy, done} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset flags: got %b expected 00000", {s_ready, weightValid, biasValid, busy, done});
        end
        n_chk++;
        if ({weightValue, biasValue, config_layer_num, config_neuron_num} !== 128'b0) begin
            n_fail++;
            $display("FAIL reset values: got %h expected 0", {weightValue, biasValue, config_layer_num, config_neuron_num});
        end
        rst = 0;
    endtask

    task automatic test_normal();
        stim = '{1, 2, 3, 10, 4, 5, 6, 20};
        do_load(2, 2, 3, 0, 0);
        build(2, 2, 3);
        n_chk++;
        if (obs.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL normal strobe count: got %0d expected %0d", obs.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            n_chk++;
            if (i >= obs.size() || obs[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL normal event %0d: got %h expected %h", i, i < obs.size() ? obs[i] : ev_t'(0), exp_q[i]);
            end
        end
        n_chk++;
        if (done_cnt != 1 || done_cyc != last_bias + 1) begin
            n_fail++;
            $display("FAIL normal done: got count %0d cycle %0d expected count 1 cycle %0d", done_cnt, done_cyc, last_bias + 1);
        end
        n_chk++;
        if (busy1 !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL normal busy: got %b/%b expected 1/0", busy1, busy);
        end
        n_chk++;
        if (dual != 0) begin
            n_fail++;
            $display("FAIL normal dual strobe: got %0d expected 0", dual);
        end
    endtask

    task automatic test_backpressure();
        stim = '{1, 2, 3, 10, 4, 5, 6, 20};
        do_load(2, 2, 3, 1, 0);
        build(2, 2, 3);
        n_chk++;
        if (obs.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL gaps strobe count: got %0d expected %0d", obs.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            n_chk++;
            if (i >= obs.size() || obs[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL gaps event %0d: got %h expected %h", i, i < obs.size() ? obs[i] : ev_t'(0), exp_q[i]);
            end
        end
        n_chk++;
        if (done_cnt != 1 || done_cyc != last_bias + 1) begin
            n_fail++;
            $display("FAIL gaps done: got count %0d cycle %0d expected count 1 cycle %0d", done_cnt, done_cyc, last_bias + 1);
        end
    endtask

    task automatic test_zero_weights();
        stim = '{7, 8, 9};
        do_load(5, 3, 0, 0, 0);
        build(5, 3, 0);
        n_chk++;
        if (obs.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL zero_w strobe count: got %0d expected %0d", obs.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            n_chk++;
            if (i >= obs.size() || obs[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL zero_w event %0d: got %h expected %h", i, i < obs.size() ? obs[i] : ev_t'(0), exp_q[i]);
            end
        end
        n_chk++;
        if (done_cnt != 1 || done_cyc != last_bias + 1) begin
            n_fail++;
            $display("FAIL zero_w done: got count %0d cycle %0d expected count 1 cycle %0d", done_cnt, done_cyc, last_bias + 1);
        end
    endtask

    task automatic test_zero_neurons();
        stim = '{32'hdead, 32'hbeef};
        do_load(9, 0, 4, 0, 0);
        n_chk++;
        if (obs.size() != 0 || ready_seen) begin
            n_fail++;
            $display("FAIL zero_n activity: got %0d strobes ready_seen %b expected 0 strobes ready_seen 0", obs.size(), ready_seen);
        end
        n_chk++;
        if (done_cnt != 1 || done_cyc != 2) begin
            n_fail++;
            $display("FAIL zero_n done: got count %0d cycle %0d expected count 1 cycle 2", done_cnt, done_cyc);
        end
        n_chk++;
        if (config_layer_num !== 32'd9 || config_neuron_num !== 32'(NB)) begin
            n_fail++;
            $display("FAIL zero_n config: got %0d/%0d expected 9/%0d", config_layer_num, config_neuron_num, NB);
        end
    endtask

    task automatic test_start_busy();
        stim = '{11, 12, 13, 14, 15, 16};
        do_load(3, 2, 2, 0, 1);
        build(3, 2, 2);
        n_chk++;
        if (obs.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL busy_start strobe count: got %0d expected %0d", obs.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            n_chk++;
            if (i >= obs.size() || obs[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL busy_start event %0d: got %h expected %h", i, i < obs.size() ? obs[i] : ev_t'(0), exp_q[i]);
            end
        end
        n_chk++;
        if (done_cnt != 1 || done_cyc != last_bias + 1) begin
            n_fail++;
            $display("FAIL busy_start done: got count %0d cycle %0d expected count 1 cycle %0d", done_cnt, done_cyc, last_bias + 1);
        end
    endtask

    task automatic test_reset_mid();
        int acc = 0;
        stim = '{1, 2, 3, 10, 4, 5, 6, 20};
        @(posedge clk); #1;
        start = 1; cfg_layer = 6; cfg_num_neurons = 2; cfg_num_weights = 3;
        @(posedge clk); #1;
        start = 0;
        s_valid = 1;
        for (int c = 0; c < 20 && acc < 2; c++) begin
            s_data = stim[acc];
            @(negedge clk);
            if (s_ready) acc++;
            @(posedge clk); #1;
        end
        rst = 1;
        s_valid = 0;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        n_chk++;
        if ({s_ready, weightValid, biasValid, busy, done} !== 5'b0) begin
            n_fail++;
            $display("FAIL mid_reset flags: got %b expected 00000", {s_ready, weightValid, biasValid, busy, done});
        end
        n_chk++;
        if ({weightValue, biasValue, config_layer_num, config_neuron_num} !== 128'b0) begin
            n_fail++;
            $display("FAIL mid_reset values: got %h expected 0", {weightValue, biasValue, config_layer_num, config_neuron_num});
        end
        do_load(6, 2, 3, 0, 0);
        build(6, 2, 3);
        n_chk++;
        if (obs.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL mid_reset reload count: got %0d expected %0d", obs.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            n_chk++;
            if (i >= obs.size() || obs[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL mid_reset reload event %0d: got %h expected %h", i, i < obs.size() ? obs[i] : ev_t'(0), exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            int nn = $urandom_range(1, 4);
            int nw = $urandom_range(0, 5);
            logic [31:0] layer = $urandom;
            stim.delete();
            for (int j = 0; j < nn * (nw + 1); j++) stim.push_back($urandom);
            do_load(layer, nn, nw, 2, k[0]);
            build(layer, nn, nw);
            n_chk++;
            if (obs.size() != exp_q.size()) begin
                n_fail++;
                $display("FAIL random%0d strobe count: got %0d expected %0d", k, obs.size(), exp_q.size());
            end
            foreach (exp_q[i]) begin
                n_chk++;
                if (i >= obs.size() || obs[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL random%0d event %0d: got %h expected %h", k, i, i < obs.size() ? obs[i] : ev_t'(0), exp_q[i]);
                end
            end
            n_chk++;
            if (done_cnt != 1 || done_cyc != last_bias + 1 || dual != 0) begin
                n_fail++;
                $display("FAIL random%0d done: got count %0d cycle %0d dual %0d expected count 1 cycle %0d dual 0", k, done_cnt, done_cyc, dual, last_bias + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_backpressure();
        test_zero_weights();
        test_zero_neurons();
        test_start_busy();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
